lpif_dstrm_rx_buffer: RTL

Downstream receive buffer that consumes the LPIF `dstrm_*` flit stream produced by the x16 half-rate slave top and presents it to the protocol layer through a valid/ready interface. The LPIF downstream channel has no backpressure, so this block absorbs rate mismatch in a DEPTH-entry FIFO. It returns one credit per consumed entry and tracks the link state. It also reports overflow and debug status.

---
 rtl/lpif_dstrm_rx_buffer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/lpif_dstrm_rx_buffer.sv
// LPIF downstream receive buffer: DEPTH-entry FIFO with credit return, link-state tracking and status.
// Optional push/drop statistics in debug_status[15:0] are enabled by defining LPIF_DSTRM_BUF_STATS_EN.
module lpif_dstrm_rx_buffer #(
   parameter int DEPTH = 4,
   parameter int CNTW  = $clog2(DEPTH) + 1
) (
   input  logic            clk_wr,
   input  logic            rst_wr_n,
   input  logic            rx_online,
   input  logic [7:0]      dstrm_state,
   input  logic [3:0]      dstrm_protid,
   input  logic [1023:0]   dstrm_data,
   input  logic [1:0]      dstrm_dvalid,
   input  logic [31:0]     dstrm_crc,
   input  logic [1:0]      dstrm_crc_valid,
   input  logic [1:0]      dstrm_valid,
   output logic            buf_valid,
   input  logic            buf_ready,
   output logic [1023:0]   buf_data,
   output logic [3:0]      buf_protid,
   output logic [1:0]      buf_dvalid,
   output logic [31:0]     buf_crc,
   output logic [1:0]      buf_crc_valid,
   output logic [1:0]      buf_flit_valid,
   output logic [7:0]      cur_state,
   output logic            state_chg,
   output logic            credit_rtn,
   output logic [CNTW-1:0] fill_level,
   output logic            overflow,
   output logic [31:0]     debug_status
);

   localparam int PW = $clog2(DEPTH);

   typedef struct packed {
      logic [3:0]    protid;
      logic [1:0]    dvalid;
      logic [31:0]   crc;
      logic [1:0]    crc_valid;
      logic [1:0]    flit_valid;
      logic [1023:0] data;
   } entry_t;

   // Handshake: an entry transfers on any edge where buf_valid && buf_ready
   // (and rx_online); buf_valid comes from the registered count only.
   entry_t          mem [DEPTH];
   entry_t          head;
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic            push, pop, full, accept, drop;
   logic [15:0]     stats;

   assign push      = rx_online && (dstrm_valid != 2'b00);
   assign buf_valid = (fill_level != '0);
   assign pop       = rx_online && buf_valid && buf_ready;
   assign full      = (fill_level == CNTW'(DEPTH));
   assign accept    = push && (!full || pop);
   assign drop      = push && full && !pop;

   always_ff @(posedge clk_wr) begin
      if (accept)
         mem[wr_ptr] <= '{protid: dstrm_protid, dvalid: dstrm_dvalid, crc: dstrm_crc,
                          crc_valid: dstrm_crc_valid, flit_valid: dstrm_valid, data: dstrm_data};
   end

   always_ff @(posedge clk_wr or negedge rst_wr_n) begin
      if (!rst_wr_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill_level <= '0;
         overflow   <= 1'b0;
         credit_rtn <= 1'b0;
      end else if (!rx_online) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill_level <= '0;
         overflow   <= 1'b0;
         credit_rtn <= 1'b0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + PW'(1);
         if (pop)    rd_ptr <= rd_ptr + PW'(1);
         fill_level <= fill_level + CNTW'(accept) - CNTW'(pop);
         if (drop) overflow <= 1'b1;
         credit_rtn <= pop;
      end
   end

   // Link-state tracking runs regardless of rx_online.
   always_ff @(posedge clk_wr or negedge rst_wr_n) begin
      if (!rst_wr_n) begin
         cur_state <= '0;
         state_chg <= 1'b0;
      end else begin
         cur_state <= dstrm_state;
         state_chg <= (dstrm_state != cur_state);
      end
   end

`ifdef LPIF_DSTRM_BUF_STATS_EN
   logic [7:0] push_cnt, drop_cnt;

   always_ff @(posedge clk_wr or negedge rst_wr_n) begin
      if (!rst_wr_n) begin
         push_cnt <= '0;
         drop_cnt <= '0;
      end else if (!rx_online) begin
         push_cnt <= '0;
         drop_cnt <= '0;
      end else begin
         if (push && push_cnt != 8'hFF) push_cnt <= push_cnt + 8'd1;
         if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
   end

   assign stats = {push_cnt, drop_cnt};
`else
   assign stats = 16'h0000;
`endif

   assign head           = mem[rd_ptr];
   assign buf_data       = head.data;
   assign buf_protid     = head.protid;
   assign buf_dvalid     = head.dvalid;
   assign buf_crc        = head.crc;
   assign buf_crc_valid  = head.crc_valid;
   assign buf_flit_valid = head.flit_valid;

   assign debug_status = {overflow, buf_valid, 2'b00, 4'(fill_level), cur_state, stats};

endmodule
